// File: rtl/audio_wave_pulsewidth_gen_pkg.sv
// audio_wave_pulsewidth_gen_pkg: shared widths, muted duty code, waveform codes and LFSR step
package audio_wave_pulsewidth_gen_pkg;
    localparam int DEF_PERWIDTH = 28;
    localparam int DEF_BITRES = 4;
    localparam int PWM_MUTED = 0;
    typedef enum logic [1:0] {
        WAVE_TRI = 2'b00,
        WAVE_SAW = 2'b01,
        WAVE_SQR = 2'b10,
        WAVE_NOISE = 2'b11
    } wave_e;
    function automatic logic [14:0] lfsr15_next(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction
endpackage

// File: rtl/audio_lfsr15.sv
// audio_lfsr15: 15-bit x^15+x^14+1 noise register, advances only when asked
module audio_lfsr15
    import audio_wave_pulsewidth_gen_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        adv,
    input  logic [14:0] seed,
    output logic [14:0] state
);
    // shift one position per advance request, reload the seed on reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= seed;
        else if (adv) state <= lfsr15_next(state);
    end
endmodule

// File: rtl/audio_wave_pulsewidth_gen.sv
// audio_wave_pulsewidth_gen: multi-waveform PWM duty generator with incremental phase divider
module audio_wave_pulsewidth_gen
    import audio_wave_pulsewidth_gen_pkg::*;
#(
    parameter int          PERWIDTH  = DEF_PERWIDTH,
    parameter int          BITRES    = DEF_BITRES,
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mute,
    input  logic [PERWIDTH-1:0] period,
    input  logic [1:0]          mode,
    input  logic [BITRES-1:0]   vol,
    output logic [BITRES-1:0]   pulsewidth,
    output logic                wrap
);
    localparam int SW = BITRES + 1;
    localparam int RES = 2 ** SW;
    localparam logic [SW-1:0] STEP_MAX = SW'(RES - 1);
    localparam logic [PERWIDTH:0] RES_A = (PERWIDTH + 1)'(RES);
    localparam logic [BITRES-1:0] MUTED = BITRES'(PWM_MUTED);

    logic [PERWIDTH-1:0] count, period_l;
    logic [PERWIDTH:0]   acc, acc_nx;
    logic [SW-1:0]       step;
    wave_e               mode_l;
    logic [14:0]         lfsr;
    logic                at_end, hit, adv, slow;
    logic [BITRES-1:0]   w;
    logic [2*BITRES-1:0] prod;

    assign at_end = count == period_l;
    assign acc_nx = acc + RES_A;
    assign hit    = acc_nx >= {1'b0, period_l};
    assign adv    = !mute && !at_end && hit && step != STEP_MAX;
    assign slow   = period_l < PERWIDTH'(RES);

    audio_lfsr15 u_lfsr (
        .clk   (clk),
        .resetn(resetn),
        .adv   (adv),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    // phase counter with Bresenham step divider; period and mode only change at a wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            acc      <= '0;
            step     <= '0;
            period_l <= '0;
            mode_l   <= WAVE_TRI;
        end else if (mute || at_end) begin
            count    <= '0;
            acc      <= '0;
            step     <= '0;
            period_l <= mute ? '0 : period;
            mode_l   <= mute ? WAVE_TRI : wave_e'(mode);
        end else begin
            count <= count + 1'b1;
            acc   <= hit ? acc_nx - {1'b0, period_l} : acc_nx;
            if (adv) step <= step + 1'b1;
        end
    end

    // waveform shape from the phase step, then amplitude scaling by vol+1
    always_comb begin
        w = mode_l == WAVE_TRI ? (step[SW-1] ? ~step[BITRES-1:0] : step[BITRES-1:0]) :
            mode_l == WAVE_SAW ? step[SW-1:1] :
            mode_l == WAVE_SQR ? (step[SW-1] ? '0 : '1) :
            BITRES'(lfsr >> (15 - BITRES));
        prod = (2*BITRES)'(w) * (2*BITRES)'({1'b0, vol} + 1'b1);
    end

    // registered duty and wrap pulse; muted on mute or unsupported short periods
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pulsewidth <= MUTED;
            wrap       <= 1'b0;
        end else begin
            pulsewidth <= (mute || slow) ? MUTED : BITRES'(prod >> BITRES);
            wrap       <= !mute && at_end;
        end
    end
endmodule

// File: tb/tb_audio_wave_pulsewidth_gen.sv
// tb_audio_wave_pulsewidth_gen: randomized scoreboard bench against an arithmetic reference model
module tb_audio_wave_pulsewidth_gen;
    localparam int RES = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mute = 1'b0;
    logic [27:0] period = 28'd63;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  vol = 4'd15;
    logic [3:0]  pulsewidth;
    logic        wrap;

    typedef struct packed {
        logic [3:0] pw;
        logic       wr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int          m_cnt = 0;
    int          m_p = 0;
    int          m_mode = 0;
    logic [14:0] m_lfsr = 15'h0001;

    always #5 clk = ~clk;

    audio_wave_pulsewidth_gen dut (
        .clk       (clk),
        .resetn    (resetn),
        .mute      (mute),
        .period    (period),
        .mode      (mode),
        .vol       (vol),
        .pulsewidth(pulsewidth),
        .wrap      (wrap)
    );

    // phase step reached c clocks into a period of p+1 clocks
    function automatic int step_of(int c, int p);
        int s;
        if (p < RES) return c;
        s = c * RES / p;
        return s > RES - 1 ? RES - 1 : s;
    endfunction

    function automatic int duty(int s, int md, logic [14:0] l, int v, int p);
        int w;
        if (p < RES) return 0;
        case (md)
            0: w = s < RES / 2 ? s : RES - 1 - s;
            1: w = s / 2;
            2: w = s < RES / 2 ? 15 : 0;
            default: w = int'(l[14:11]);
        endcase
        return w * (v + 1) / 16;
    endfunction

    function automatic logic [14:0] lfsr_adv(logic [14:0] l);
        return {l[13:0], l[14] ^ l[13]};
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_p = 0;
        m_mode = 0;
        m_lfsr = 15'h0001;
    endtask

    // model one clock edge with the inputs now applied and queue the expected outputs
    task automatic tick();
        exp_t e;
        if (mute) begin
            e = '{pw: 4'd0, wr: 1'b0};
            m_cnt = 0;
            m_p = 0;
            m_mode = 0;
        end else begin
            e.pw = 4'(duty(step_of(m_cnt, m_p), m_mode, m_lfsr, int'(vol), m_p));
            e.wr = m_cnt == m_p;
            if (m_cnt == m_p) begin
                m_cnt = 0;
                m_p = int'(period);
                m_mode = int'(mode);
            end else begin
                if (step_of(m_cnt + 1, m_p) > step_of(m_cnt, m_p)) m_lfsr = lfsr_adv(m_lfsr);
                m_cnt++;
            end
        end
        q.push_back(e);
    endtask

    task automatic step_in(bit mu, int per, int md, int v);
        @(negedge clk);
        resetn = 1'b1;
        mute = mu;
        period = 28'(per);
        mode = 2'(md);
        vol = 4'(v);
        tick();
    endtask

    task automatic run(int n, int per, int md, int v);
        for (int i = 0; i < n; i++) step_in(1'b0, per, md, v);
    endtask

    task automatic check_reset(string tag);
        #1;
        checks++;
        if (pulsewidth !== 4'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL %s pw=%0d wrap=%0b expected pw=0 wrap=0", tag, pulsewidth, wrap);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        check_reset("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic random_phase();
        int per, md, v, n;
        for (int b = 0; b < 30; b++) begin
            per = $urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom_range(32, 260);
            md = $urandom_range(0, 3);
            v = $urandom_range(0, 15);
            n = $urandom_range(20, 150);
            for (int k = 0; k < n; k++) step_in($urandom_range(0, 63) == 0, per, md, v);
            if (b == 15) async_reset();
        end
    endtask

    // scoreboard monitor: compare each registered output against the queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (pulsewidth !== e.pw || wrap !== e.wr) begin
                errors++;
                $display("FAIL scoreboard t=%0t pw=%0d wrap=%0b expected pw=%0d wrap=%0b",
                         $time, pulsewidth, wrap, e.pw, e.wr);
            end
        end
    end

    initial begin
        #2 resetn = 1'b0;
        check_reset("reset_state");
        model_reset();
        repeat (2) @(negedge clk);
        run(1 + 128, 63, 0, 15);
        run(130, 63, 1, 15);
        run(130, 63, 2, 15);
        run(20, 63, 0, 15);
        run(300, 127, 0, 15);
        run(30, 63, 3, 15);
        step_in(1'b1, 63, 3, 15);
        run(200, 63, 3, 15);
        run(70, 20, 0, 15);
        run(200, 63, 3, 15);
        run(200, 63, 3, 7);
        async_reset();
        run(150, 63, 3, 15);
        random_phase();
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
